// File: rtl/wave_gen_pkg.sv
// Shared definitions for the waveform sample generator: select encoding,
// default widths, and the per-shape sample mapping.
package wave_gen_pkg;

    localparam int DATA_W    = 8;
    localparam int ACC_W     = 16;
    localparam int INC_SHIFT = 6;

    localparam logic [7:0] MIDSCALE = 8'h80;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SINE   = 2'd3
    } wave_e;

    // Map an 8-bit phase (and the registered quarter-sine magnitude) to an
    // offset-binary sample for the selected shape.
    function automatic logic [DATA_W-1:0] shape_sample(input wave_e      sel,
                                                       input logic [7:0] p,
                                                       input logic [6:0] m);
        logic [7:0] t;
        logic [7:0] r;
        t = {p[6:0], 1'b0};
        case (sel)
            WAVE_SQUARE: r = p[7] ? 8'h00 : 8'hFF;
            WAVE_SAW:    r = p;
            WAVE_TRI:    r = p[7] ? ~t : t;
            WAVE_SINE:   r = p[7] ? (8'd127 - {1'b0, m}) : (8'd128 + {1'b0, m});
            default:     r = MIDSCALE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// First-quadrant sine magnitude table: ROM[i] = round(127*sin(pi/2*(i+0.5)/64)).
// The half-sample offset makes the quadrant mirror exactly, so the folded
// address never needs a separate peak entry. Output is registered.
module quarter_sine_rom (
    input  logic       clk,
    input  logic       en,
    input  logic [5:0] addr,
    output logic [6:0] data
);

    // Capture the table entry for the addressed phase when a sample is accepted.
    always_ff @(posedge clk) begin
        if (en) begin
            case (addr)
                6'd0:  data <= 7'd2;    6'd1:  data <= 7'd5;
                6'd2:  data <= 7'd8;    6'd3:  data <= 7'd11;
                6'd4:  data <= 7'd14;   6'd5:  data <= 7'd17;
                6'd6:  data <= 7'd20;   6'd7:  data <= 7'd23;
                6'd8:  data <= 7'd26;   6'd9:  data <= 7'd29;
                6'd10: data <= 7'd32;   6'd11: data <= 7'd35;
                6'd12: data <= 7'd38;   6'd13: data <= 7'd41;
                6'd14: data <= 7'd44;   6'd15: data <= 7'd47;
                6'd16: data <= 7'd50;   6'd17: data <= 7'd53;
                6'd18: data <= 7'd56;   6'd19: data <= 7'd58;
                6'd20: data <= 7'd61;   6'd21: data <= 7'd64;
                6'd22: data <= 7'd67;   6'd23: data <= 7'd69;
                6'd24: data <= 7'd72;   6'd25: data <= 7'd74;
                6'd26: data <= 7'd77;   6'd27: data <= 7'd79;
                6'd28: data <= 7'd82;   6'd29: data <= 7'd84;
                6'd30: data <= 7'd86;   6'd31: data <= 7'd89;
                6'd32: data <= 7'd91;   6'd33: data <= 7'd93;
                6'd34: data <= 7'd95;   6'd35: data <= 7'd97;
                6'd36: data <= 7'd99;   6'd37: data <= 7'd101;
                6'd38: data <= 7'd103;  6'd39: data <= 7'd105;
                6'd40: data <= 7'd106;  6'd41: data <= 7'd108;
                6'd42: data <= 7'd110;  6'd43: data <= 7'd111;
                6'd44: data <= 7'd113;  6'd45: data <= 7'd114;
                6'd46: data <= 7'd115;  6'd47: data <= 7'd117;
                6'd48: data <= 7'd118;  6'd49: data <= 7'd119;
                6'd50: data <= 7'd120;  6'd51: data <= 7'd121;
                6'd52: data <= 7'd122;  6'd53: data <= 7'd123;
                6'd54: data <= 7'd124;  6'd55: data <= 7'd124;
                6'd56: data <= 7'd125;  6'd57: data <= 7'd125;
                6'd58: data <= 7'd126;  6'd59: data <= 7'd126;
                6'd60: data <= 7'd127;  6'd61: data <= 7'd127;
                6'd62: data <= 7'd127;  6'd63: data <= 7'd127;
                default: data <= 7'd0;
            endcase
        end else begin
            data <= data;
        end
    end

endmodule

// File: rtl/wave_sample_gen.sv
// Waveform sample source for the parallel-DAC write path. Each accepted
// request steps a phase accumulator and runs a two-stage pipeline:
// stage 1 holds the phase, shape and sine magnitude; stage 2 is DB itself.
// Requests arriving while either stage is occupied are dropped and flagged.
module wave_sample_gen #(
    parameter int DATA_W    = wave_gen_pkg::DATA_W,
    parameter int ACC_W     = wave_gen_pkg::ACC_W,
    parameter int INC_SHIFT = wave_gen_pkg::INC_SHIFT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [1:0]        Fsel,
    input  logic [2:0]        Fr,
    input  logic              sample_req,
    output logic [DATA_W-1:0] DB,
    output logic              sample_valid,
    output logic              overrun
);

    import wave_gen_pkg::*;

    logic [ACC_W-1:0] acc;
    wave_e            cfg_sel;
    logic             s1_valid;
    logic [7:0]       s1_phase;
    wave_e            s1_sel;
    logic [6:0]       rom_data;

    logic             accept;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   acc_sum;
    logic [7:0]       phase_now;
    logic [5:0]       rom_addr;
    logic [DATA_W-1:0] shape_val;

    // Accept decode, phase step and folded sine address for the current phase.
    always_comb begin
        accept    = sample_req & ~s1_valid & ~sample_valid;
        inc       = ACC_W'(1) << (int'(Fr) + INC_SHIFT);
        acc_sum   = {1'b0, acc} + {1'b0, inc};
        phase_now = acc[ACC_W-1 -: 8];
        if (phase_now[6]) begin
            rom_addr = ~phase_now[5:0];
        end else begin
            rom_addr = phase_now[5:0];
        end
        shape_val = shape_sample(s1_sel, s1_phase, rom_data);
    end

    quarter_sine_rom u_rom (
        .clk  (Clk),
        .en   (accept),
        .addr (rom_addr),
        .data (rom_data)
    );

    // Accumulator, shape latch at period boundaries, pipeline and sticky overrun.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc          <= '0;
            cfg_sel      <= wave_e'(Fsel);
            s1_valid     <= 1'b0;
            s1_phase     <= 8'h00;
            s1_sel       <= WAVE_SQUARE;
            DB           <= MIDSCALE;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= s1_valid;
            if (s1_valid) begin
                DB <= shape_val;
            end
            s1_valid <= accept;
            if (accept) begin
                // The sample taken on the wrapping step keeps the old shape;
                // the new select only applies from the next accepted sample.
                s1_phase <= phase_now;
                s1_sel   <= cfg_sel;
                acc      <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W]) begin
                    cfg_sel <= wave_e'(Fsel);
                end
            end
            if (sample_req && !accept) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wave_sample_gen.sv
// Directed bench for wave_sample_gen with a scoreboard of expected samples.
module tb_wave_sample_gen;

    logic       Clk        = 1'b0;
    logic       Rst        = 1'b1;
    logic [1:0] Fsel       = 2'd1;
    logic [2:0] Fr         = 3'd7;
    logic       sample_req = 1'b0;
    logic [7:0] DB;
    logic       sample_valid;
    logic       overrun;

    wave_sample_gen dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Fsel         (Fsel),
        .Fr           (Fr),
        .sample_req   (sample_req),
        .DB           (DB),
        .sample_valid (sample_valid),
        .overrun      (overrun)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] val;
        int         due;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         edge_no  = 0;
    logic       rst_seen = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_db     = 8'h80;

    logic [15:0] m_acc  = 16'h0000;
    logic [1:0]  m_sel  = 2'd1;
    logic        m_ovr  = 1'b0;
    int          m_free = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_shape(input logic [1:0] sel, input logic [7:0] p);
        logic [7:0] t;
        logic [5:0] q;
        int         m;
        real        ang;
        case (sel)
            2'd0: return p[7] ? 8'h00 : 8'hFF;
            2'd1: return p;
            2'd2: begin
                t = {p[6:0], 1'b0};
                return p[7] ? ~t : t;
            end
            default: begin
                q   = p[6] ? ~p[5:0] : p[5:0];
                ang = 3.14159265358979 / 2.0 * ($itor(q) + 0.5) / 64.0;
                m   = $rtoi(127.0 * $sin(ang) + 0.5);
                return p[7] ? 8'(127 - m) : 8'(128 + m);
            end
        endcase
    endfunction

    always @(posedge Clk) begin
        edge_no  <= edge_no + 1;
        rst_seen <= Rst;
    end

    // Output monitor: exact valid timing, sample values, and DB hold between updates.
    always @(negedge Clk) begin
        if (rst_seen) begin
            sb.delete();
            m_db = 8'h80;
            check("reset_overrun", overrun, 32'd0);
        end
        if (sb.size() > 0 && sb[0].due == edge_no) begin
            mon_e = sb.pop_front();
            check("valid_pulse", sample_valid, 32'd1);
            check("db_value", DB, mon_e.val);
            m_db = mon_e.val;
        end else begin
            check("valid_idle", sample_valid, 32'd0);
            check("db_hold", DB, m_db);
        end
    end

    task automatic reset_model();
        m_acc  = 16'h0000;
        m_sel  = Fsel;
        m_ovr  = 1'b0;
        m_free = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
    endtask

    // Hold sample_req high for len cycles, modelling accept/drop for each.
    task automatic do_req(input int len);
        logic [16:0] s;
        @(posedge Clk);
        #1;
        sample_req = 1'b1;
        repeat (len) begin
            if (edge_no >= m_free) begin
                sb.push_back('{val: model_shape(m_sel, m_acc[15:8]), due: edge_no + 2});
                s = {1'b0, m_acc} + (17'd1 << (int'(Fr) + 6));
                m_acc = s[15:0];
                if (s[16]) m_sel = Fsel;
                m_free = edge_no + 3;
            end else begin
                m_ovr = 1'b1;
            end
            @(posedge Clk);
            #1;
        end
        sample_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        reset_model();
        check("idle_overrun", overrun, 32'd0);

        // Sawtooth, one request every 4 cycles; switch to square mid-period.
        for (int i = 0; i < 10; i++) begin
            do_req(1);
            idle(2);
        end
        Fsel = 2'd0;
        for (int i = 0; i < 6; i++) begin
            do_req(1);
            idle(2);
        end
        // Square period, then triangle, then sine (each armed before its boundary).
        for (int i = 0; i < 8; i++) begin
            if (i == 4) Fsel = 2'd2;
            do_req(1);
            idle(2);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 4) Fsel = 2'd3;
            do_req(1);
            idle(2);
        end
        for (int i = 0; i < 8; i++) begin
            do_req(1);
            idle(2);
        end
        // Full-resolution sine sweep at maximum throughput.
        Fr = 3'd2;
        for (int i = 0; i < 256; i++) begin
            do_req(1);
            idle(1);
        end
        idle(3);
        check("no_overrun_yet", overrun, 32'd0);

        // Consecutive requests: second is dropped, accumulator advances once.
        do_req(2);
        idle(3);
        check("overrun_set", overrun, 32'(m_ovr));
        check("overrun_sticky_model", 32'(m_ovr), 32'd1);
        do_req(1);
        idle(3);
        check("overrun_held", overrun, 32'd1);

        // Reset one cycle after an accepted request: the sample is discarded.
        Fr = 3'd7;
        do_req(1);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        reset_model();
        check("overrun_cleared", overrun, 32'd0);
        check("db_midscale", DB, 32'h80);
        do_req(1);
        idle(4);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
